wrr_scheduler: RTL and testbench

WRR_SCHEDULER -- requirements
Module: wrr_scheduler

---
 rtl/wrr_scheduler_if.sv | 44 ++++
 rtl/wrr_scheduler.sv | 123 ++++++++++++
 tb/tb_wrr_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wrr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module     : wrr_scheduler_if
// Description: Bundles the FIFO-side signals of the weighted round-robin
//              scheduler (input FIFO heads/pops, output FIFO pushes/data).
// Revision   : 1.0 - initial release
// ============================================================================
interface wrr_scheduler_if #(
  parameter int DATA_W = 10,
  parameter int WGT_W  = 3
);
  logic              empty_P0, empty_P1, empty_P2, empty_P3;
  logic              almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3;
  logic [DATA_W-1:0] in_FIFO_0, in_FIFO_1, in_FIFO_2, in_FIFO_3;
  logic [4*WGT_W-1:0] cfg_weight;
  logic              pop_F0, pop_F1, pop_F2, pop_F3;
  logic              push_F0, push_F1, push_F2, push_F3;
  logic [DATA_W-1:0] out_FIFO_0, out_FIFO_1, out_FIFO_2, out_FIFO_3;
  logic              grant_vld;
  logic [1:0]        grant_idx;

  modport master (
    input  empty_P0, empty_P1, empty_P2, empty_P3,
    input  almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    input  in_FIFO_0, in_FIFO_1, in_FIFO_2, in_FIFO_3,
    input  cfg_weight,
    output pop_F0, pop_F1, pop_F2, pop_F3,
    output push_F0, push_F1, push_F2, push_F3,
    output out_FIFO_0, out_FIFO_1, out_FIFO_2, out_FIFO_3,
    output grant_vld, grant_idx
  );

  modport slave (
    output empty_P0, empty_P1, empty_P2, empty_P3,
    output almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    output in_FIFO_0, in_FIFO_1, in_FIFO_2, in_FIFO_3,
    output cfg_weight,
    input  pop_F0, pop_F1, pop_F2, pop_F3,
    input  push_F0, push_F1, push_F2, push_F3,
    input  out_FIFO_0, out_FIFO_1, out_FIFO_2, out_FIFO_3,
    input  grant_vld, grant_idx
  );
endinterface
`default_nettype wire

// File: rtl/wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : wrr_scheduler
// Description: 4x4 weighted round-robin crossbar scheduler; one grant per
//              cycle, forwarded word appears on the output FIFO one cycle later.
// Revision   : 1.0 - initial release
// ============================================================================
module wrr_scheduler #(
  parameter int DATA_W = 10,
  parameter int WGT_W  = 3
) (
  input  wire logic         clk,
  input  wire logic         reset,
  wrr_scheduler_if.master   bus
);

  logic [3:0]        w_empty;
  logic [3:0]        w_af;
  logic [DATA_W-1:0] w_in  [4];
  logic [1:0]        w_dst [4];
  logic [3:0]        w_elig;

  logic              w_gnt;
  logic [1:0]        w_g;
  logic [3:0]        w_pop;
  logic [WGT_W-1:0]  w_cfg_wt;
  logic [WGT_W-1:0]  w_new_wt;
  logic [WGT_W-1:0]  w_cur_wt;
  logic              w_last;

  logic [1:0]        r_ptr;
  logic [WGT_W-1:0]  r_cnt;
  logic [WGT_W-1:0]  r_wt;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_out [4];
  logic              r_vld;
  logic [1:0]        r_idx;

  assign w_empty = {bus.empty_P3, bus.empty_P2, bus.empty_P1, bus.empty_P0};
  assign w_af    = {bus.almost_full_P3, bus.almost_full_P2,
                    bus.almost_full_P1, bus.almost_full_P0};
  assign w_in[0] = bus.in_FIFO_0;
  assign w_in[1] = bus.in_FIFO_1;
  assign w_in[2] = bus.in_FIFO_2;
  assign w_in[3] = bus.in_FIFO_3;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_elig
      assign w_dst[i]  = w_in[i][DATA_W-1:DATA_W-2];
      assign w_elig[i] = !w_empty[i] && !w_af[w_dst[i]];
    end
  endgenerate

  // Scan from farthest to nearest so the queue closest to ptr wins.
  always_comb begin
    logic [1:0] v_idx;
    w_gnt = 1'b0;
    w_g   = r_ptr;
    v_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_ptr + 2'(k);
      if (w_elig[v_idx]) begin
        w_gnt = 1'b1;
        w_g   = v_idx;
      end
    end
  end

  assign w_pop = (w_gnt && !reset) ? (4'b0001 << w_g) : 4'b0000;

  // A turn's weight is sampled when it starts and held until it ends.
  assign w_cfg_wt = bus.cfg_weight[r_ptr*WGT_W +: WGT_W];
  assign w_new_wt = (w_cfg_wt == '0) ? WGT_W'(1) : w_cfg_wt;
  assign w_cur_wt = (r_cnt == '0) ? w_new_wt : r_wt;
  assign w_last   = ((WGT_W+1)'(r_cnt) + (WGT_W+1)'(1)) >= (WGT_W+1)'(w_cur_wt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= 2'd0;
      r_cnt  <= '0;
      r_wt   <= WGT_W'(1);
      r_push <= 4'b0000;
      r_vld  <= 1'b0;
      r_idx  <= 2'd0;
      for (int j = 0; j < 4; j++) r_out[j] <= '0;
    end else begin
      if (r_cnt == '0) r_wt <= w_new_wt;
      r_push <= 4'b0000;
      r_vld  <= w_gnt;
      if (w_gnt) begin
        r_push[w_dst[w_g]] <= 1'b1;
        r_out[w_dst[w_g]]  <= w_in[w_g];
        r_idx              <= w_g;
        if (w_g != r_ptr) begin
          r_ptr <= w_g + 2'd1;
          r_cnt <= '0;
        end else if (w_last) begin
          r_ptr <= r_ptr + 2'd1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + WGT_W'(1);
        end
      end
    end
  end

  assign bus.pop_F0     = w_pop[0];
  assign bus.pop_F1     = w_pop[1];
  assign bus.pop_F2     = w_pop[2];
  assign bus.pop_F3     = w_pop[3];
  assign bus.push_F0    = r_push[0];
  assign bus.push_F1    = r_push[1];
  assign bus.push_F2    = r_push[2];
  assign bus.push_F3    = r_push[3];
  assign bus.out_FIFO_0 = r_out[0];
  assign bus.out_FIFO_1 = r_out[1];
  assign bus.out_FIFO_2 = r_out[2];
  assign bus.out_FIFO_3 = r_out[3];
  assign bus.grant_vld  = r_vld;
  assign bus.grant_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_wrr_scheduler
// Description: Table-driven self-checking bench for wrr_scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_wrr_scheduler;

  localparam int DATA_W = 10;
  localparam int WGT_W  = 3;

  logic clk;
  logic reset;

  wrr_scheduler_if #(.DATA_W(DATA_W), .WGT_W(WGT_W)) bus ();

  wrr_scheduler #(.DATA_W(DATA_W), .WGT_W(WGT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  empty;
    logic [3:0]  af;
    logic [7:0]  dsts;
    logic [11:0] wgt;
    int          g;
  } vec_t;

  typedef struct {
    logic             rst;
    int               g;
    logic [1:0]       dst;
    logic [DATA_W-1:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [11:0] c_W1   = {3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] c_W034 = {3'd1, 3'd1, 3'd1, 3'd3};
  localparam logic [11:0] c_WA   = {3'd1, 3'd1, 3'd2, 3'd1};
  localparam logic [11:0] c_WZ   = {3'd0, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] c_WB   = {3'd1, 3'd1, 3'd3, 3'd1};
  localparam logic [7:0]  c_D0   = 8'h00;
  localparam logic [7:0]  c_DM   = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [7:0]  c_D12  = {2'd0, 2'd0, 2'd2, 2'd0};

  task automatic add(input logic r, input logic [3:0] e, input logic [3:0] a,
                     input logic [7:0] d, input logic [11:0] w, input int g);
    vec_t v;
    v.rst = r; v.empty = e; v.af = a; v.dsts = d; v.wgt = w; v.g = g;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int step);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkdata(input logic [1:0] dst, input int k, input int i);
    return {dst, 6'(k), 2'(i)};
  endfunction

  initial begin
    vec_t v;
    exp_t ex;
    logic [3:0] pops;
    logic [3:0] pushes;
    logic [4*DATA_W-1:0] outs;
    logic [1:0] last_idx;
    logic [3:0] exp_pop;

    // Reset, then idle with everything empty.
    add(1, 4'hF, 4'h0, c_D0, c_W1, -1);
    add(0, 4'hF, 4'h0, c_D0, c_W1, -1);
    add(0, 4'hF, 4'h0, c_D0, c_W1, -1);
    // Unit weights, all busy, dst 0.
    add(0, 4'h0, 4'h0, c_D0, c_W1, 0);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 1);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 2);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 3);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 0);
    // Q0 weight 3, mixed destinations (ptr starts at 1).
    add(0, 4'h0, 4'h0, c_DM, c_W034, 1);
    add(0, 4'h0, 4'h0, c_DM, c_W034, 2);
    add(0, 4'h0, 4'h0, c_DM, c_W034, 3);
    for (int r = 0; r < 2; r++) begin
      add(0, 4'h0, 4'h0, c_DM, c_W034, 0);
      add(0, 4'h0, 4'h0, c_DM, c_W034, 0);
      add(0, 4'h0, 4'h0, c_DM, c_W034, 0);
      if (r == 0) begin
        add(0, 4'h0, 4'h0, c_DM, c_W034, 1);
        add(0, 4'h0, 4'h0, c_DM, c_W034, 2);
        add(0, 4'h0, 4'h0, c_DM, c_W034, 3);
      end
    end
    // Mid-turn weight change keeps the latched weight; weight 0 acts as 1.
    add(0, 4'h0, 4'h0, c_DM, c_WA, 1);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 1);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 2);
    add(0, 4'h0, 4'h0, c_DM, c_WZ, 3);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 0);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 1);
    // Q1 blocked by almost_full_P2, then released.
    add(0, 4'h0, 4'h4, c_D12, c_W1, 2);
    add(0, 4'h0, 4'h4, c_D12, c_W1, 3);
    add(0, 4'h0, 4'h4, c_D12, c_W1, 0);
    add(0, 4'h0, 4'h4, c_D12, c_W1, 2);
    add(0, 4'h0, 4'h4, c_D12, c_W1, 3);
    add(0, 4'h0, 4'h4, c_D12, c_W1, 0);
    add(0, 4'h0, 4'h0, c_D12, c_W1, 1);
    // Only Q3 busy with ptr 0: wrap back to 0.
    add(0, 4'h0, 4'h0, c_D0, c_W1, 2);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 3);
    add(0, 4'h7, 4'h0, c_D0, c_W1, 3);
    add(0, 4'h7, 4'h0, c_D0, c_W1, 3);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 0);
    // Forfeit a partially used turn.
    add(0, 4'h0, 4'h0, c_DM, c_WB, 1);
    add(0, 4'h2, 4'h0, c_DM, c_WB, 2);
    add(0, 4'h0, 4'h0, c_DM, c_WB, 3);
    add(0, 4'h0, 4'h0, c_DM, c_WB, 0);
    add(0, 4'h0, 4'h0, c_DM, c_WB, 1);
    // Reset while Q2 would be popped.
    add(1, 4'h2, 4'h0, c_DM, c_WB, -1);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 0);
    add(0, 4'h0, 4'h0, c_DM, c_W1, 1);
    // All destinations blocked, then released.
    add(0, 4'h0, 4'h1, c_D0, c_W1, -1);
    add(0, 4'h0, 4'h0, c_D0, c_W1, 2);
    add(0, 4'hF, 4'h0, c_D0, c_W1, -1);
    add(0, 4'hF, 4'h0, c_D0, c_W1, -1);

    last_idx = 2'd0;
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      reset              = v.rst;
      bus.empty_P0       = v.empty[0];
      bus.empty_P1       = v.empty[1];
      bus.empty_P2       = v.empty[2];
      bus.empty_P3       = v.empty[3];
      bus.almost_full_P0 = v.af[0];
      bus.almost_full_P1 = v.af[1];
      bus.almost_full_P2 = v.af[2];
      bus.almost_full_P3 = v.af[3];
      bus.in_FIFO_0      = mkdata(v.dsts[1:0], k, 0);
      bus.in_FIFO_1      = mkdata(v.dsts[3:2], k, 1);
      bus.in_FIFO_2      = mkdata(v.dsts[5:4], k, 2);
      bus.in_FIFO_3      = mkdata(v.dsts[7:6], k, 3);
      bus.cfg_weight     = v.wgt;
      #1;
      pops    = {bus.pop_F3, bus.pop_F2, bus.pop_F1, bus.pop_F0};
      exp_pop = (v.g >= 0) ? (4'b0001 << v.g) : 4'b0000;
      chk("pop", 64'(pops), 64'(exp_pop), k);

      ex.rst  = v.rst;
      ex.g    = v.g;
      ex.dst  = (v.g >= 0) ? v.dsts[2*v.g +: 2] : 2'd0;
      ex.data = (v.g >= 0) ? mkdata(ex.dst, k, v.g) : '0;
      sb.push_back(ex);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty step=%0d actual=0 expected=1", k);
      end else begin
        ex     = sb.pop_front();
        pushes = {bus.push_F3, bus.push_F2, bus.push_F1, bus.push_F0};
        outs   = {bus.out_FIFO_3, bus.out_FIFO_2, bus.out_FIFO_1, bus.out_FIFO_0};
        if (ex.rst) last_idx = 2'd0;
        if (ex.g >= 0) begin
          chk("push", 64'(pushes), 64'(4'b0001 << ex.dst), k);
          chk("grant_vld", 64'(bus.grant_vld), 64'd1, k);
          chk("grant_idx", 64'(bus.grant_idx), 64'(ex.g), k);
          chk("out_data", 64'(outs[ex.dst*DATA_W +: DATA_W]), 64'(ex.data), k);
          last_idx = 2'(ex.g);
        end else begin
          chk("push_idle", 64'(pushes), 64'd0, k);
          chk("grant_vld_idle", 64'(bus.grant_vld), 64'd0, k);
          chk("grant_idx_hold", 64'(bus.grant_idx), 64'(last_idx), k);
          if (ex.rst) chk("out_reset", 64'(outs), 64'd0, k);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
